instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Packs decoded instruction fields into one 32-bit RV32I instruction word: type, opcode, funct3, funct7, rd, rs1, rs2 and a full 32-bit immediate.
- Performs the inverse of the immediate generator and checks that the immediate fits the chosen format.
- Serves as the write-side front end for the instruction-memory loader and self-checking benches.
- Uses a valid/ready handshake on both sides, a registered output stage, and a wrapping word-address counter that goes with each emitted word.

Parameters:
- ADDR_W, 10, width of the word address output.
- START_ADDR, 0, value loaded into the address counter at reset and on clear.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  synchronous reset of the address counter and output stage; reset has priority over clear.
- valid_i  in  1  input fields are valid.
- ready_o  out  1  encoder can accept a transfer.
- type_i  in  3  format select, using the shared RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE encodings.
- opcode_i  in  7  instr[6:0].
- funct3_i  in  3  instr[14:12].
- funct7_i  in  7  instr[31:25]; R-type only.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  signed immediate for I/S/B/J; full upper value for U.
- valid_o  out  1  output word is valid.
- ready_i  in  1  downstream accepts the word.
- instr_o  out  32  encoded instruction.
- addr_o  out  ADDR_W  word address tagged to instr_o.
- err_o  out  1  immediate not representable; qualified by valid_o.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - valid_o=0, instr_o=0, err_o=0, addr_o=START_ADDR.
  - Any in-flight word is dropped.
- ready_o = !valid_o || ready_i. This is combinational and gives full throughput with no bubble.
- Accept when valid_i && ready_o. The encoded word, err_o and the current counter value are registered together; valid_o=1 on the next cycle. Latency is 1 cycle.
- Output hold: while valid_o && !ready_i, instr_o, addr_o and err_o stay stable.
- Output retire: on valid_o && ready_i with no new accept, valid_o drops to 0.
- Address counter:
  - Increments by 1 on each input accept; addr_o shows the pre-increment value.
  - Wraps from 2^ADDR_W-1 to 0 with no flag.
- clear_i: counter returns to START_ADDR and valid_o=0; an input accept in the same cycle is discarded.
- Bit packing (opcode_i always at [6:0]):
  - R: funct7_i | rs2 | rs1 | funct3 | rd.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Range check (err_o=1 when violated):
  - I/S: imm_i[31:11] all equal.
  - B: imm_i[31:12] all equal and imm_i[0]=0.
  - J: imm_i[31:20] all equal and imm_i[0]=0.
  - U: imm_i[11:0]=0.
  - R: imm_i ignored, never an error.
- Undefined type_i: instr_o=32'h0000_0013 (NOP), err_o=1.
- On a range error the word is still emitted with the truncated fields and still consumes an address.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: range checks and undefined-type flagging as above.
- Undefined:
  - err_o is tied to 0.
  - Immediates are silently truncated.
  - Undefined type_i still produces a NOP, with no flag.
  - The checker logic is removed.

Decomposition:
- Shared package: type encodings (RTYPE..JTYPE), a NOP constant, RV32I opcode constants, and a packed struct for the input fields.
- One sub-module: instr_pack, purely combinational. It maps fields plus type to {instr, err}.
- The top level holds the handshake register, the counter and the clear logic.

Test Plan:
- ITYPE, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> instr_o=0x00500093, err_o=0, addr_o=0, one cycle after accept.
- Back-to-back, ready_i=1:
  - STYPE, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423 @ addr 0.
  - BTYPE, opcode 0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3 @ addr 1.
  - No bubble between them.
- UTYPE, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7. Then JTYPE, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF.
- Error cases:
  - ITYPE imm=2048 -> err_o=1, instr_o[31:20]=0x800.
  - BTYPE imm=3 -> err_o=1.
  - type_i=3'b111 -> instr_o=0x00000013, err_o=1.
  - Without the macro, err_o stays 0 in all of these.
- Backpressure and wrap, ADDR_W=2:
  - Hold ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0, outputs stable.
  - Then 5 accepts -> addr_o sequence 0,1,2,3,0.
- Mid-stream events:
  - rst_ni=0 while valid_o=1 -> next cycle valid_o=0, addr_o=START_ADDR.
  - clear_i coincident with valid_i -> that word is dropped.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format selects,
// opcode constants, the NOP word and the packed input-field bundle.
package instr_encoder_pkg;

    // Format select values carried on type_i; 3'd6 and 3'd7 are undefined.
    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        ITYPE = 3'd1,
        STYPE = 3'd2,
        BTYPE = 3'd3,
        UTYPE = 3'd4,
        JTYPE = 3'd5
    } instr_type_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6F;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpReg    = 7'h33;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: maps decoded fields plus format select to a
// 32-bit RV32I word and an immediate-range error flag.
// Macro IMM_RANGE_CHECK_EN enables the range checker; otherwise err_o is 0.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  type_i,
    input  fields_t     fields_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [31:0] imm;
    assign imm = fields_i.imm;

    // Bit packing per format; undefined formats fall back to a NOP.
    always_comb begin
        instr_o = NopInstr;
        case (type_i)
            RTYPE: instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                              fields_i.funct3, fields_i.rd, fields_i.opcode};
            ITYPE: instr_o = {imm[11:0], fields_i.rs1, fields_i.funct3,
                              fields_i.rd, fields_i.opcode};
            STYPE: instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1,
                              fields_i.funct3, imm[4:0], fields_i.opcode};
            BTYPE: instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1,
                              fields_i.funct3, imm[4:1], imm[11], fields_i.opcode};
            UTYPE: instr_o = {imm[31:12], fields_i.rd, fields_i.opcode};
            JTYPE: instr_o = {imm[20], imm[10:1], imm[11], imm[19:12],
                              fields_i.rd, fields_i.opcode};
            default: instr_o = NopInstr;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every bit above the format's sign bit matches it.
    logic fits_12;
    logic fits_13;
    logic fits_21;
    assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

    // Range check per format; undefined formats are always flagged.
    always_comb begin
        err_o = 1'b0;
        case (type_i)
            RTYPE:        err_o = 1'b0;
            ITYPE, STYPE: err_o = !fits_12;
            BTYPE:        err_o = !fits_13 || imm[0];
            UTYPE:        err_o = |imm[11:0];
            JTYPE:        err_o = !fits_21 || imm[0];
            default:      err_o = 1'b1;
        endcase
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder top: valid/ready input, one registered output
// stage and a wrapping word-address counter tagged to each emitted word.
// Macro IMM_RANGE_CHECK_EN (in instr_pack) enables immediate range checking.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        type_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

    fields_t     fields;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic        accept;

    logic              valid_d, valid_q;
    logic [31:0]       instr_d, instr_q;
    logic              err_d, err_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q;

    assign fields = '{opcode: opcode_i, funct3: funct3_i, funct7: funct7_i,
                      rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};

    instr_pack u_pack (
        .type_i   (type_i),
        .fields_i (fields),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    // Next-state: clear beats accept; accept loads a fresh word and bumps the counter.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            valid_d = 1'b0;
            instr_d = '0;
            err_d   = 1'b0;
            addr_d  = StartAddr;
            cnt_d   = StartAddr;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = pack_instr;
            err_d   = pack_err;
            addr_d  = cnt_q;
            cnt_d   = cnt_q + 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output stage and address counter with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= StartAddr;
            cnt_q   <= StartAddr;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign err_o   = err_q;
    assign addr_o  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder. Main DUT uses ADDR_W=2 to
// exercise wrap; a second instance (ADDR_W=3, START_ADDR=5) shares inputs.
module tb_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [2:0]  type_i = 3'd0;
    logic [6:0]  opcode_i = 7'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [6:0]  funct7_i = 7'd0;
    logic [4:0]  rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
    logic [31:0] imm_i = 32'd0;

    logic        ready_o, valid_o, err_o;
    logic [31:0] instr_o;
    logic [1:0]  addr_o;
    logic        ready2_o, valid2_o, err2_o;
    logic [31:0] instr2_o;
    logic [2:0]  addr2_o;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(2), .START_ADDR(0)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .ready_o(ready_o), .type_i(type_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .addr_o(addr_o),
        .err_o(err_o)
    );

    instr_encoder #(.ADDR_W(3), .START_ADDR(5)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .ready_o(ready2_o), .type_i(type_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .valid_o(valid2_o), .ready_i(ready_i), .instr_o(instr2_o), .addr_o(addr2_o),
        .err_o(err2_o)
    );

    task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        type_i = t; opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm; valid_i = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; valid_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_o); else n_pass++;
        n_checks++; if (instr_o !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else n_pass++;
        n_checks++; if (addr_o !== 2'd0) $display("FAIL reset_addr got %0d exp 0", addr_o); else n_pass++;
        n_checks++; if (addr2_o !== 3'd5) $display("FAIL reset_addr_start got %0d exp 5", addr2_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready_o); else n_pass++;
    endtask

    task automatic test_itype();
        do_reset();
        drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL itype_valid got %b exp 1", valid_o); else n_pass++;
        n_checks++; if (instr_o !== 32'h00500093) $display("FAIL itype_instr got %h exp 00500093", instr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL itype_err got %b exp 0", err_o); else n_pass++;
        n_checks++; if (addr_o !== 2'd0) $display("FAIL itype_addr got %0d exp 0", addr_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) $display("FAIL itype_retire got %b exp 0", valid_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        @(negedge clk);
        n_checks++; if (instr_o !== 32'h0020A423) $display("FAIL b2b_s_instr got %h exp 0020a423", instr_o); else n_pass++;
        n_checks++; if (addr_o !== 2'd0) $display("FAIL b2b_s_addr got %0d exp 0", addr_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ready_o); else n_pass++;
        drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL b2b_bubble got %b exp 1", valid_o); else n_pass++;
        n_checks++; if (instr_o !== 32'hFE000EE3) $display("FAIL b2b_b_instr got %h exp fe000ee3", instr_o); else n_pass++;
        n_checks++; if (addr_o !== 2'd1) $display("FAIL b2b_b_addr got %0d exp 1", addr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL b2b_b_err got %b exp 0", err_o); else n_pass++;
    endtask

    task automatic test_u_j_r();
        do_reset();
        drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        @(negedge clk);
        n_checks++; if (instr_o !== 32'h123452B7) $display("FAIL utype_instr got %h exp 123452b7", instr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL utype_err got %b exp 0", err_o); else n_pass++;
        drive(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        @(negedge clk);
        n_checks++; if (instr_o !== 32'h001000EF) $display("FAIL jtype_instr got %h exp 001000ef", instr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL jtype_err got %b exp 0", err_o); else n_pass++;
        n_checks++; if (addr_o !== 2'd1) $display("FAIL jtype_addr got %0d exp 1", addr_o); else n_pass++;
        // sub x1, x2, x3 with a junk immediate that must be ignored
        drive(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (instr_o !== 32'h403100B3) $display("FAIL rtype_instr got %h exp 403100b3", instr_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rtype_err got %b exp 0", err_o); else n_pass++;
    endtask

    task automatic test_errors();
        do_reset();
        drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
        @(negedge clk);
        n_checks++; if (instr_o[31:20] !== 12'h800) $display("FAIL err_i_imm got %h exp 800", instr_o[31:20]); else n_pass++;
        n_checks++; if (err_o !== ErrEn) $display("FAIL err_i_flag got %b exp %b", err_o, ErrEn); else n_pass++;
        drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        @(negedge clk);
        n_checks++; if (instr_o !== 32'h00000163) $display("FAIL err_b_instr got %h exp 00000163", instr_o); else n_pass++;
        n_checks++; if (err_o !== ErrEn) $display("FAIL err_b_flag got %b exp %b", err_o, ErrEn); else n_pass++;
        n_checks++; if (addr_o !== 2'd1) $display("FAIL err_b_addr got %0d exp 1", addr_o); else n_pass++;
        drive(3'd7, 7'h33, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h5555_5555);
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (instr_o !== 32'h00000013) $display("FAIL err_nop_instr got %h exp 00000013", instr_o); else n_pass++;
        n_checks++; if (err_o !== ErrEn) $display("FAIL err_nop_flag got %b exp %b", err_o, ErrEn); else n_pass++;
    endtask

    task automatic test_backpressure_wrap();
        logic [1:0] exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] exp_addr2 [5] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        do_reset();
        ready_i = 1'b0;
        drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            // Changed fields must not leak into the held word
            imm_i = 32'd100 + 32'(i);
            n_checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, ready_o); else n_pass++;
            @(negedge clk);
            n_checks++; if (instr_o !== 32'h00500093 || addr_o !== 2'd0 || valid_o !== 1'b1)
                $display("FAIL bp_hold[%0d] got %h/%0d/%b exp 00500093/0/1", i, instr_o, addr_o, valid_o);
            else n_pass++;
        end
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (addr_o !== exp_addr[i]) $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, addr_o, exp_addr[i]); else n_pass++;
            n_checks++; if (addr2_o !== exp_addr2[i]) $display("FAIL wrap_addr2[%0d] got %0d exp %0d", i, addr2_o, exp_addr2[i]); else n_pass++;
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_midstream();
        do_reset();
        ready_i = 1'b0;
        drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", valid_o); else n_pass++;
        n_checks++; if (addr2_o !== 3'd5) $display("FAIL mid_rst_addr got %0d exp 5", addr2_o); else n_pass++;
        ready_i = 1'b1;
        drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        n_checks++; if (addr_o !== 2'd0 || valid_o !== 1'b1) $display("FAIL mid_pre_clear got %0d/%b exp 0/1", addr_o, valid_o); else n_pass++;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_clear_drop got %b exp 0", valid_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_clear_idle got %b exp 0", valid_o); else n_pass++;
        drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        @(negedge clk);
        valid_i = 1'b0;
        n_checks++; if (addr_o !== 2'd0) $display("FAIL mid_clear_addr got %0d exp 0", addr_o); else n_pass++;
        n_checks++; if (addr2_o !== 3'd5) $display("FAIL mid_clear_addr2 got %0d exp 5", addr2_o); else n_pass++;
        n_checks++; if (instr_o !== 32'h123452B7) $display("FAIL mid_after_clear got %h exp 123452b7", instr_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_u_j_r();
        test_errors();
        test_backpressure_wrap();
        test_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
